// File: rtl/fpu_round_pkg.sv
// Shared rounding-mode codes, stage-1 control payload and exponent helper constant
// for the mul/add result rounders.
package fpu_round_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RUP = 3'b010;
    localparam logic [2:0] RM_RDN = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    // Wide all-ones source; each rounder slices it down to its own exponent width.
    localparam logic [63:0] EXP_ONES_WIDE = '1;

    typedef struct packed {
        logic sz;
        logic rnd;
        logic gs;
        logic pass;
        logic to_inf;
    } s1_ctl_t;

endpackage

// File: rtl/round_decide.sv
// Combinational round-up decision from mode, sign, LSB, guard and sticky.
// Optional macro ROUND_RMM_EN adds round-to-nearest-ties-away for mode 100.
module round_decide
    import fpu_round_pkg::*;
(
    input  logic [2:0] r_mode_i,
    input  logic       sz_i,
    input  logic       l_i,
    input  logic       g_i,
    input  logic       s_i,
    output logic       rnd_o
);

    always_comb begin
        rnd_o = g_i & (l_i | s_i);
        case (r_mode_i)
            RM_RTZ:  rnd_o = 1'b0;
            RM_RUP:  rnd_o = ~sz_i & (g_i | s_i);
            RM_RDN:  rnd_o = sz_i & (g_i | s_i);
`ifdef ROUND_RMM_EN
            RM_RMM:  rnd_o = g_i;
`else
`endif
            default: rnd_o = g_i & (l_i | s_i);
        endcase
    end

endmodule

// File: rtl/round_unit_pipe.sv
// Two-stage pipelined IEEE rounder with valid/ready on both sides.
// Optional macro ROUND_RMM_EN enables ties-away mode (code 100) in round_decide.
module round_unit_pipe
    import fpu_round_pkg::*;
#(
    parameter int MAN_W   = 23,
    parameter int EXP_W   = 8,
    parameter int W_EXTRA = 3
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       In_valid,
    output logic                       In_ready,
    input  logic                       Sz,
    input  logic [2:0]                 R_mode,
    input  logic                       T,
    input  logic [EXP_W-1:0]           Exp_in,
    input  logic [MAN_W+W_EXTRA:0]     Man_in,
    output logic                       Out_valid,
    input  logic                       Out_ready,
    output logic                       Sz_out,
    output logic [EXP_W-1:0]           Exp_out,
    output logic [MAN_W:0]             Mz,
    output logic                       Inexact,
    output logic                       Overflow
);

    localparam logic [EXP_W-1:0] EXP_ONES = EXP_ONES_WIDE[EXP_W-1:0];

    logic                 s1_valid_q, s1_valid_d;
    logic [MAN_W:0]       s1_man_q, s1_man_d;
    logic [EXP_W-1:0]     s1_exp_q, s1_exp_d;
    s1_ctl_t              s1_ctl_q, s1_ctl_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sz_q, s2_sz_d;
    logic [EXP_W-1:0]     s2_exp_q, s2_exp_d;
    logic [MAN_W:0]       s2_mz_q, s2_mz_d;
    logic                 s2_inexact_q, s2_inexact_d;
    logic                 s2_ovf_q, s2_ovf_d;

    logic                 s1_adv;
    logic                 lsb, guard, sticky, rnd;
    logic [MAN_W+1:0]     sum;
    logic [MAN_W:0]       mz_r;
    logic [EXP_W-1:0]     exp_r;
    logic                 inexact_r, ovf_r;

    assign s1_adv   = ~s2_valid_q | Out_ready;
    assign In_ready = ~s1_valid_q | s1_adv;

    assign lsb    = Man_in[W_EXTRA];
    assign guard  = Man_in[W_EXTRA-1];
    assign sticky = (|Man_in[W_EXTRA-2:0]) | T;

    round_decide u_decide (
        .r_mode_i (R_mode),
        .sz_i     (Sz),
        .l_i      (lsb),
        .g_i      (guard),
        .s_i      (sticky),
        .rnd_o    (rnd)
    );

    // Stage 1 captures the truncated mantissa and the decided increment.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_man_d   = s1_man_q;
        s1_exp_d   = s1_exp_q;
        s1_ctl_d   = s1_ctl_q;
        if (In_ready) begin
            s1_valid_d = In_valid;
            if (In_valid) begin
                s1_man_d        = Man_in[MAN_W+W_EXTRA:W_EXTRA];
                s1_exp_d        = Exp_in;
                s1_ctl_d.sz     = Sz;
                s1_ctl_d.rnd    = rnd;
                s1_ctl_d.gs     = guard | sticky;
                s1_ctl_d.pass   = (Exp_in == EXP_ONES);
                s1_ctl_d.to_inf = ~((R_mode == RM_RTZ) |
                                    ((R_mode == RM_RUP) & Sz) |
                                    ((R_mode == RM_RDN) & ~Sz));
            end
        end
    end

    assign sum = {1'b0, s1_man_q} + {{(MAN_W+1){1'b0}}, s1_ctl_q.rnd};

    // Stage 2: apply increment, renormalise, then saturate on exponent overflow.
    always_comb begin
        mz_r      = sum[MAN_W:0];
        exp_r     = s1_exp_q;
        inexact_r = s1_ctl_q.gs;
        ovf_r     = 1'b0;
        if (s1_ctl_q.pass) begin
            mz_r      = s1_man_q;
            inexact_r = 1'b0;
        end else begin
            if (sum[MAN_W+1]) begin
                mz_r  = {1'b1, sum[MAN_W:1]};
                exp_r = s1_exp_q + EXP_W'(1);
            end else if ((s1_exp_q == '0) && !s1_man_q[MAN_W] && sum[MAN_W]) begin
                exp_r = EXP_W'(1);
            end
            if (exp_r == EXP_ONES) begin
                ovf_r     = 1'b1;
                inexact_r = 1'b1;
                if (s1_ctl_q.to_inf) begin
                    mz_r = '0;
                end else begin
                    exp_r = EXP_ONES - EXP_W'(1);
                    mz_r  = '1;
                end
            end
        end
    end

    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_sz_d      = s2_sz_q;
        s2_exp_d     = s2_exp_q;
        s2_mz_d      = s2_mz_q;
        s2_inexact_d = s2_inexact_q;
        s2_ovf_d     = s2_ovf_q;
        if (s1_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sz_d      = s1_ctl_q.sz;
                s2_exp_d     = exp_r;
                s2_mz_d      = mz_r;
                s2_inexact_d = inexact_r;
                s2_ovf_d     = ovf_r;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_q   <= 1'b0;
            s1_man_q     <= '0;
            s1_exp_q     <= '0;
            s1_ctl_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_sz_q      <= 1'b0;
            s2_exp_q     <= '0;
            s2_mz_q      <= '0;
            s2_inexact_q <= 1'b0;
            s2_ovf_q     <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_man_q     <= s1_man_d;
            s1_exp_q     <= s1_exp_d;
            s1_ctl_q     <= s1_ctl_d;
            s2_valid_q   <= s2_valid_d;
            s2_sz_q      <= s2_sz_d;
            s2_exp_q     <= s2_exp_d;
            s2_mz_q      <= s2_mz_d;
            s2_inexact_q <= s2_inexact_d;
            s2_ovf_q     <= s2_ovf_d;
        end
    end

    assign Out_valid = s2_valid_q;
    assign Sz_out    = s2_sz_q;
    assign Exp_out   = s2_exp_q;
    assign Mz        = s2_mz_q;
    assign Inexact   = s2_inexact_q;
    assign Overflow  = s2_ovf_q;

endmodule

// File: tb/tb_round_unit_pipe.sv
// Scoreboard bench for round_unit_pipe: directed corner beats plus randomized traffic
// against an arithmetic reference model, with a decoupled output monitor.
module tb_round_unit_pipe;

    typedef struct packed {
        logic        sz;
        logic [7:0]  exp;
        logic [23:0] mz;
        logic        inexact;
        logic        ovf;
    } beat_t;

    logic        CLK;
    logic        RST;
    logic        In_valid;
    logic        In_ready;
    logic        Sz;
    logic [2:0]  R_mode;
    logic        T;
    logic [7:0]  Exp_in;
    logic [26:0] Man_in;
    logic        Out_valid;
    logic        Out_ready;
    logic        Sz_out;
    logic [7:0]  Exp_out;
    logic [23:0] Mz;
    logic        Inexact;
    logic        Overflow;

    int    checks = 0;
    int    errors = 0;
    int    cycleCount = 0;
    bit    readyRandom = 0;
    beat_t expQ[$];

    round_unit_pipe #(.MAN_W(23), .EXP_W(8), .W_EXTRA(3)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Sz        (Sz),
        .R_mode    (R_mode),
        .T         (T),
        .Exp_in    (Exp_in),
        .Man_in    (Man_in),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .Sz_out    (Sz_out),
        .Exp_out   (Exp_out),
        .Mz        (Mz),
        .Inexact   (Inexact),
        .Overflow  (Overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount <= cycleCount + 1;

    // Random downstream backpressure while the randomized phase runs.
    always @(negedge CLK) begin
        if (readyRandom) Out_ready = ($urandom_range(0, 3) != 0);
    end

    // Reference rounding from the arithmetic rules: integer add, halve on carry-out.
    function automatic beat_t refRound(input logic sz, input logic [2:0] mode, input logic t,
                                       input logic [7:0] expIn, input logic [23:0] man,
                                       input logic [2:0] extra);
        beat_t       r;
        int unsigned val;
        int          e;
        bit          g, s, up, toInf;
        r.sz = sz;
        if (expIn == 8'd255) begin
            r.exp = expIn; r.mz = man; r.inexact = 1'b0; r.ovf = 1'b0;
            return r;
        end
        g = extra[2];
        s = (extra[1:0] != 2'b00) || t;
        case (mode)
            3'd1: up = 1'b0;
            3'd2: up = !sz && (g || s);
            3'd3: up = sz && (g || s);
`ifdef ROUND_RMM_EN
            3'd4: up = g;
`else
`endif
            default: up = g && (man[0] || s);
        endcase
        val = man + up;
        e   = expIn;
        if (val >= 2**24) begin
            val = val / 2;
            e   = e + 1;
        end else if (expIn == 0 && man < 2**23 && val >= 2**23) begin
            e = 1;
        end
        r.inexact = g || s;
        r.ovf     = 1'b0;
        if (e == 255) begin
            r.ovf     = 1'b1;
            r.inexact = 1'b1;
            toInf = !(mode == 3'd1 || (mode == 3'd2 && sz) || (mode == 3'd3 && !sz));
            if (toInf) begin
                val = 0;
            end else begin
                e   = 254;
                val = 2**24 - 1;
            end
        end
        r.exp = 8'(e);
        r.mz  = 24'(val);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic driveBeat(input logic sz, input logic [2:0] mode, input logic t,
                             input logic [7:0] expIn, input logic [23:0] man, input logic [2:0] extra);
        Sz       = sz;
        R_mode   = mode;
        T        = t;
        Exp_in   = expIn;
        Man_in   = {man, extra};
        In_valid = 1'b1;
    endtask

    // Offers one beat from a falling edge; returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic sz, input logic [2:0] mode, input logic t,
                                 input logic [7:0] expIn, input logic [23:0] man, input logic [2:0] extra);
        int waited = 0;
        bit done   = 0;
        driveBeat(sz, mode, t, expIn, man, extra);
        while (!done) begin
            #4;
            if (In_ready) begin
                expQ.push_back(refRound(sz, mode, t, expIn, man, extra));
                done = 1;
            end else if (waited >= 200) begin
                checkOutput("accept_timeout", {63'd0, In_ready}, 64'd1);
                done = 1;
            end
            waited++;
            @(negedge CLK);
        end
    endtask

    task automatic idleCycles(input int n);
        In_valid = 1'b0;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drainQueue(input int budget);
        int n = 0;
        Out_ready = 1'b1;
        In_valid  = 1'b0;
        while (expQ.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
    endtask

    // Monitor: pops on every output transfer and checks stalled outputs stay frozen.
    initial begin
        bit          stalled = 0;
        logic [35:0] held = '0;
        beat_t       got, want;
        forever begin
            @(negedge CLK);
            #4;
            if (!RST) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    checkOutput("stall_hold", 64'({Out_valid, Sz_out, Exp_out, Mz, Inexact, Overflow}), 64'(held));
                end
                if (Out_valid && Out_ready) begin
                    got = '{Sz_out, Exp_out, Mz, Inexact, Overflow};
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_beat", 64'(got), 64'd0);
                    end else begin
                        want = expQ.pop_front();
                        checkOutput("beat", 64'(got), 64'(want));
                    end
                end
                stalled = Out_valid && !Out_ready;
                held    = {Out_valid, Sz_out, Exp_out, Mz, Inexact, Overflow};
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int    startCycle;
        int    rsel;
        logic  rsz, rt;
        logic  [2:0] rmode, rextra;
        logic  [7:0] rexp;
        logic  [23:0] rman;

        RST = 1'b0; In_valid = 1'b0; Out_ready = 1'b0;
        Sz = 1'b0; R_mode = 3'd0; T = 1'b0; Exp_in = '0; Man_in = '0;

        repeat (3) @(negedge CLK);
        #4 checkOutput("reset_outputs", 64'({Out_valid, Sz_out, Exp_out, Mz, Inexact, Overflow}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        Out_ready = 1'b1;
        #4 checkOutput("inready_after_reset", {63'd0, In_ready}, 64'd1);
        @(negedge CLK);

        $display("[TB] directed corner beats");
        applyStimulus(1'b0, 3'd0, 1'b0, 8'h80, 24'h800000, 3'b100);
        applyStimulus(1'b0, 3'd0, 1'b0, 8'h80, 24'h800001, 3'b100);
        applyStimulus(1'b0, 3'd1, 1'b0, 8'h80, 24'h800001, 3'b100);
        applyStimulus(1'b1, 3'd0, 1'b0, 8'h80, 24'hFFFFFF, 3'b110);
        applyStimulus(1'b0, 3'd0, 1'b0, 8'hFE, 24'hFFFFFF, 3'b111);
        applyStimulus(1'b0, 3'd1, 1'b0, 8'hFE, 24'hFFFFFF, 3'b111);
        applyStimulus(1'b1, 3'd2, 1'b0, 8'hFE, 24'hFFFFFF, 3'b111);
        applyStimulus(1'b0, 3'd3, 1'b0, 8'hFE, 24'hFFFFFF, 3'b111);
        applyStimulus(1'b1, 3'd3, 1'b0, 8'hFE, 24'hFFFFFF, 3'b111);
        applyStimulus(1'b1, 3'd0, 1'b1, 8'hFF, 24'hC00001, 3'b111);
        applyStimulus(1'b0, 3'd0, 1'b0, 8'h00, 24'h7FFFFF, 3'b100);
        applyStimulus(1'b0, 3'd4, 1'b0, 8'h40, 24'h800000, 3'b100);
        applyStimulus(1'b0, 3'd2, 1'b1, 8'h40, 24'h800000, 3'b000);
        idleCycles(1);

        startCycle = cycleCount;
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 3'd0, 1'b0, 8'h10 + 8'(i), 24'h800000 + 24'(i), 3'(i));
        checkOutput("throughput_cycles", 64'(cycleCount - startCycle), 64'd8);
        drainQueue(20);

        $display("[TB] backpressure");
        Out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 8'h21, 24'h900000, 3'b101);
        applyStimulus(1'b1, 3'd2, 1'b0, 8'h22, 24'hA00001, 3'b011);
        driveBeat(1'b0, 3'd3, 1'b1, 8'h23, 24'hB00002, 3'b000);
        for (int i = 0; i < 4; i++) begin
            #4 checkOutput("inready_full", {63'd0, In_ready}, 64'd0);
            @(negedge CLK);
        end
        Out_ready = 1'b1;
        applyStimulus(1'b0, 3'd3, 1'b1, 8'h23, 24'hB00002, 3'b000);
        applyStimulus(1'b1, 3'd0, 1'b0, 8'h24, 24'hC00003, 3'b100);
        drainQueue(20);

        $display("[TB] reset with beats in flight");
        Out_ready = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0, 8'h31, 24'h812345, 3'b110);
        applyStimulus(1'b1, 3'd0, 1'b0, 8'h32, 24'h854321, 3'b010);
        In_valid = 1'b0;
        RST = 1'b0;
        expQ.delete();
        #4 checkOutput("reset_flush_valid", {63'd0, Out_valid}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        Out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #4 checkOutput("no_stale_beat", {63'd0, Out_valid}, 64'd0);
            @(negedge CLK);
        end

        $display("[TB] randomized traffic");
        readyRandom = 1;
        for (int i = 0; i < 300; i++) begin
            rsel   = int'($urandom_range(0, 9));
            rsz    = 1'($urandom);
            rt     = ($urandom_range(0, 3) == 0);
            rmode  = 3'($urandom);
            rextra = 3'($urandom);
            rman   = 24'($urandom);
            if ($urandom_range(0, 3) == 0) rman[22:0] = '1;
            case (rsel)
                0:       begin rexp = 8'h00; rman[23] = 1'b0; end
                1:       rexp = 8'hFF;
                2:       begin rexp = 8'hFE; rman[23] = 1'b1; end
                default: begin rexp = 8'($urandom_range(1, 253)); rman[23] = 1'b1; end
            endcase
            applyStimulus(rsz, rmode, rt, rexp, rman, rextra);
            if ($urandom_range(0, 4) == 0) idleCycles(1);
        end
        readyRandom = 0;
        @(negedge CLK);
        drainQueue(100);
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
